// File: rtl/i2c_rx_pkg.sv
// Shared constants for the I2C receive datapath.
package i2c_rx_pkg;

  localparam int unsigned I2C_BYTE_W = 8;
  localparam int unsigned BIT_CNT_W  = $clog2(I2C_BYTE_W) + 1;
  localparam int unsigned RX_STATE_W = 2;

  localparam logic [RX_STATE_W-1:0] RX_IDLE  = 2'd0;
  localparam logic [RX_STATE_W-1:0] RX_SHIFT = 2'd1;
  localparam logic [RX_STATE_W-1:0] RX_HOLD  = 2'd2;

endpackage

// File: rtl/i2c_rx_fifo.sv
// RX FIFO: storage, pointers, occupancy, registered read port, overflow/underflow.
module i2c_rx_fifo
  import i2c_rx_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       core_clk,
  input  logic                       rst,
  input  logic                       wr_req,
  input  logic [I2C_BYTE_W-1:0]      wr_data,
  input  logic                       rd_en,
  input  logic                       clr_err,
  output logic [I2C_BYTE_W-1:0]      rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [I2C_BYTE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_nxt;
  logic                  do_rd;
  logic                  do_wr;

  // A pop while full frees the slot the simultaneous write lands in.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_req & (~full | do_rd);

  // Next occupancy from accepted write/pop.
  always_comb begin
    count_nxt = count;
    case ({do_wr, do_rd})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage array; old entry is read before being overwritten in the same cycle.
  always_ff @(posedge core_clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy, status, read port and sticky flags.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        rd_data <= mem[rd_ptr];
      end
      rd_valid  <= do_rd;
      count     <= count_nxt;
      empty     <= (count_nxt == CNT_W'(0));
      full      <= (count_nxt == CNT_W'(DEPTH));
      overflow  <= (overflow  & ~clr_err) | (wr_req & ~do_wr);
      underflow <= (underflow & ~clr_err) | (rd_en & empty);
    end
  end

endmodule

// File: rtl/i2c_rx_datapath.sv
// I2C receive datapath: bus synchronisers, byte assembly FSM and RX FIFO.
module i2c_rx_datapath
  import i2c_rx_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   core_clk,
  input  logic                   rst,
  input  logic                   scl,
  input  logic                   sda,
  input  logic                   converter_enable,
  input  logic                   fifo_rx_enable,
  input  logic                   rd_en,
  input  logic                   clr_err,
  output logic [I2C_BYTE_W-1:0]  rd_data,
  output logic                   rd_valid,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   frame_error
);

  logic [SYNC_STAGES-1:0]  scl_pipe;
  logic [SYNC_STAGES-1:0]  sda_pipe;
  logic                    scl_s;
  logic                    sda_s;
  logic                    scl_prev;
  logic                    scl_rise;
  logic                    ce_q, ce_qq;
  logic                    push_q, push_qq;
  logic                    ce_rise, ce_fall, push_rise;
  logic [RX_STATE_W-1:0]   state_q, state_d;
  logic [I2C_BYTE_W-1:0]   shreg;
  logic [BIT_CNT_W-1:0]    bit_cnt;
  logic                    shift_en;
  logic                    cnt_clr;
  logic                    wr_req;
  logic                    ferr_set;

  // Bus line synchronisers, preset to the idle-high bus level.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      scl_pipe <= '1;
      sda_pipe <= '1;
      scl_prev <= 1'b1;
    end else begin
      scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl};
      sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda};
      scl_prev <= scl_s;
    end
  end

  assign scl_s    = scl_pipe[SYNC_STAGES-1];
  assign sda_s    = sda_pipe[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_prev;

  // Controller strobes are registered, so their edges lag the inputs by one cycle.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      ce_q    <= 1'b0;
      ce_qq   <= 1'b0;
      push_q  <= 1'b0;
      push_qq <= 1'b0;
    end else begin
      ce_q    <= converter_enable;
      ce_qq   <= ce_q;
      push_q  <= fifo_rx_enable;
      push_qq <= push_q;
    end
  end

  assign ce_rise   = ce_q & ~ce_qq;
  assign ce_fall   = ~ce_q & ce_qq;
  assign push_rise = push_q & ~push_qq;

  // FSM state register.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) state_q <= RX_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (ce_rise) state_d = RX_SHIFT;
      RX_SHIFT: begin
        if (ce_fall || push_rise) state_d = RX_IDLE;
        else if (scl_rise && (bit_cnt == BIT_CNT_W'(I2C_BYTE_W - 1))) state_d = RX_HOLD;
      end
      RX_HOLD: begin
        if (push_rise)    state_d = RX_IDLE;
        else if (ce_rise) state_d = RX_SHIFT;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // FSM control outputs.
  always_comb begin
    shift_en = 1'b0;
    cnt_clr  = 1'b0;
    wr_req   = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_clr  = ce_rise;
        ferr_set = push_rise;
      end
      RX_SHIFT: begin
        if (ce_fall || push_rise) ferr_set = 1'b1;
        else                      shift_en = scl_rise;
      end
      RX_HOLD: begin
        if (push_rise) begin
          wr_req = 1'b1;
        end else if (ce_rise) begin
          ferr_set = 1'b1;
          cnt_clr  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Shift register and bit counter, MSB first.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (cnt_clr) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      shreg   <= {shreg[I2C_BYTE_W-2:0], sda_s};
      bit_cnt <= bit_cnt + BIT_CNT_W'(1);
    end
  end

  // Sticky frame error; a new error wins over a simultaneous clear.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) frame_error <= 1'b0;
    else     frame_error <= (frame_error & ~clr_err) | ferr_set;
  end

  i2c_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .core_clk  (core_clk),
    .rst       (rst),
    .wr_req    (wr_req),
    .wr_data   (shreg),
    .rd_en     (rd_en),
    .clr_err   (clr_err),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

endmodule
